// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: shared types, constants and FSM states for the instruction-memory responder.
package imem_responder_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic        enable_t;

    localparam data_t RV_NOP    = 32'h0000_0013;
    localparam addr_t IMEM_BASE = 32'h0000_1000;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t;
endpackage

// File: rtl/imem_responder_array.sv
// imem_array: word storage with a load write port and an enabled, registered read port.
module imem_array
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  enable_t       ld_en_i,
    input  logic [IW-1:0] ld_idx_i,
    input  data_t         ld_data_i,
    input  enable_t       rd_en_i,
    input  logic          rd_nop_i,
    input  logic [IW-1:0] rd_idx_i,
    output data_t         rd_data_o
);
    data_t mem_q [DEPTH];
    data_t rd_q;

    // Storage is never reset; a same-edge load is invisible to the read.
    always_ff @(posedge clk) begin
        if (ld_en_i) mem_q[ld_idx_i] <= ld_data_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rd_q <= RV_NOP;
        else if (rd_en_i) rd_q <= rd_nop_i ? RV_NOP : mem_q[rd_idx_i];
    end

    assign rd_data_o = rd_q;
endmodule

// File: rtl/imem_responder.sv
// imem_responder: fetch-side request/grant/rvalid responder with fixed wait, flush and load port.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned IMEM_SIZE   = 4096,
    parameter addr_t       BASE_ADDR   = IMEM_BASE,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  req_i,
    input  addr_t addr_i,
    output logic  gnt_o,
    input  logic  flush_i,
    output logic  rvalid_o,
    output data_t rdata_o,
    output logic  err_o,
    input  logic  ld_en_i,
    input  addr_t ld_addr_i,
    input  data_t ld_data_i
);
    localparam int unsigned DEPTH   = IMEM_SIZE / 4;
    localparam int unsigned IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

    imem_state_t   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q;
    logic          bad_q, err_q;
    logic          accept, rd_en, req_bad, ld_ok;
    logic [32:0]   req_off, ld_off;

    // 33-bit offset: anything below the base wraps to a huge value and fails the range test.
    function automatic logic [32:0] offset(addr_t a);
        return {1'b0, a} - {1'b0, BASE_ADDR};
    endfunction

    function automatic logic bad(logic [32:0] off);
        return off[1:0] != 2'b00 || off >= 33'(IMEM_SIZE);
    endfunction

    assign req_off  = offset(addr_i);
    assign ld_off   = offset(ld_addr_i);
    assign req_bad  = bad(req_off);
    assign ld_ok    = ld_en_i && !bad(ld_off);
    assign gnt_o    = (state_q == IDLE || state_q == RESP) && !flush_i;
    assign accept   = req_i && gnt_o;
    assign rvalid_o = state_q == RESP && !flush_i;
    assign rd_en    = (accept && WAIT_CYCLES == 0) || (state_q == WAIT && !flush_i && cnt_q == 4'd1);
    assign err_o    = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT: begin
                state_d = flush_i ? IDLE : (cnt_q == 4'd1 ? RESP : WAIT);
                cnt_d   = flush_i ? 4'd0 : cnt_q - 4'd1;
            end
            default: begin
                state_d = !accept ? IDLE : (WAIT_CYCLES == 0 ? RESP : WAIT);
                cnt_d   = accept ? WAIT_LD : 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q <= req_off[IW+1:2];
                bad_q <= req_bad;
            end
            if (rd_en) err_q <= accept ? req_bad : bad_q;
        end
    end

    imem_array #(.DEPTH(DEPTH), .IW(IW)) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_en_i  (ld_ok),
        .ld_idx_i (ld_off[IW+1:2]),
        .ld_data_i(ld_data_i),
        .rd_en_i  (rd_en),
        .rd_nop_i (accept ? req_bad : bad_q),
        .rd_idx_i (accept ? req_off[IW+1:2] : idx_q),
        .rd_data_o(rdata_o)
    );
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: scoreboard bench over three responders (wait 0, 2, 3) sharing one stimulus bus.
module tb_imem_responder;
    import imem_responder_pkg::*;

    typedef struct {
        data_t data;
        logic  err;
        int    cyc;
    } exp_t;

    logic  clk = 1'b0, rst_n = 1'b0, req = 1'b0, flush = 1'b0, ld_en = 1'b0;
    addr_t addr = '0, ld_addr = '0;
    data_t ld_data = '0;
    logic  gnt [3];
    logic  rv [3];
    logic  er [3];
    data_t rd [3];
    data_t mem_m [1024];
    addr_t alist [$];
    exp_t  sb [$];
    int    wl [3] = '{0, 2, 3};
    int    ncmp = 0, nfail = 0;

    always #5 clk = ~clk;

    imem_responder #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .gnt_o(gnt[0]), .flush_i(flush),
        .rvalid_o(rv[0]), .rdata_o(rd[0]), .err_o(er[0]),
        .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data));
    imem_responder #(.WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .gnt_o(gnt[1]), .flush_i(flush),
        .rvalid_o(rv[1]), .rdata_o(rd[1]), .err_o(er[1]),
        .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data));
    imem_responder #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .gnt_o(gnt[2]), .flush_i(flush),
        .rvalid_o(rv[2]), .rdata_o(rd[2]), .err_o(er[2]),
        .ld_en_i(ld_en), .ld_addr_i(ld_addr), .ld_data_i(ld_data));

    function automatic logic in_range(addr_t a);
        return a[1:0] == 2'b00 && a >= 32'h1000 && a < 32'h2000;
    endfunction

    function automatic exp_t model(addr_t a);
        exp_t  e;
        addr_t off;
        off    = a - 32'h1000;
        e.err  = !in_range(a);
        e.data = e.err ? 32'h0000_0013 : mem_m[off[11:2]];
        e.cyc  = 0;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = 1'b0;
        flush = 1'b0;
        ld_en = 1'b0;
        repeat (6) step();
    endtask

    task automatic load(input addr_t a, input data_t d);
        addr_t off;
        step();
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        off = a - 32'h1000;
        if (in_range(a)) mem_m[off[11:2]] = d;
        step();
        ld_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            ncmp += 4;
            if (rv[k] !== 1'b0) begin nfail++; $display("FAIL reset_rvalid k=%0d got %b want 0", k, rv[k]); end
            if (rd[k] !== RV_NOP) begin nfail++; $display("FAIL reset_rdata k=%0d got %h want %h", k, rd[k], RV_NOP); end
            if (er[k] !== 1'b0) begin nfail++; $display("FAIL reset_err k=%0d got %b want 0", k, er[k]); end
            if (gnt[k] !== 1'b1) begin nfail++; $display("FAIL reset_gnt k=%0d got %b want 1", k, gnt[k]); end
        end
    endtask

    task automatic do_loads();
        load(32'h1000, 32'h0050_0093);
        load(32'h1004, 32'h00a0_0113);
        load(32'h1008, 32'h0020_8193);
        load(32'h100C, 32'h0010_8093);
        load(32'h1FFC, 32'h0000_006F);
        load(32'h1001, 32'hFFFF_FFFF);
        load(32'h2000, 32'hEEEE_EEEE);
        load(32'h0FFC, 32'hDDDD_DDDD);
    endtask

    // Streams alist through instance k; grant, data, error and latency come from the bench model.
    task automatic test_fetch(input int k, input string name);
        int   i = 0, cyc = 0, busy = 0;
        exp_t e;
        sb.delete();
        idle();
        while ((i < alist.size() || sb.size() != 0) && cyc < 200) begin
            step();
            cyc++;
            req = i < alist.size();
            addr = req ? alist[i] : '0;
            @(negedge clk);
            if (rv[k]) begin
                if (sb.size() == 0) begin
                    ncmp++;
                    nfail++;
                    $display("FAIL %s spurious_rvalid cyc=%0d got 1 want 0", name, cyc);
                end else begin
                    e = sb.pop_front();
                    ncmp += 3;
                    if (rd[k] !== e.data) begin nfail++; $display("FAIL %s rdata cyc=%0d got %h want %h", name, cyc, rd[k], e.data); end
                    if (er[k] !== e.err) begin nfail++; $display("FAIL %s err cyc=%0d got %b want %b", name, cyc, er[k], e.err); end
                    if (cyc !== e.cyc) begin nfail++; $display("FAIL %s latency got cyc %0d want cyc %0d", name, cyc, e.cyc); end
                end
            end
            ncmp++;
            if (gnt[k] !== (busy == 0)) begin nfail++; $display("FAIL %s gnt cyc=%0d got %b want %b", name, cyc, gnt[k], busy == 0); end
            if (busy > 0) busy--;
            else if (req) begin
                e = model(addr);
                e.cyc = cyc + 1 + wl[k];
                sb.push_back(e);
                i++;
                busy = wl[k];
            end
        end
        req = 1'b0;
        ncmp++;
        if (cyc >= 200) begin nfail++; $display("FAIL %s timeout pending=%0d want 0", name, sb.size()); end
    endtask

    task automatic test_flush_wait();
        idle();
        req = 1'b1;
        addr = 32'h1004;
        @(negedge clk);
        ncmp++;
        if (gnt[1] !== 1'b1) begin nfail++; $display("FAIL flush_wait accept_gnt got %b want 1", gnt[1]); end
        step();
        req = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        ncmp += 2;
        if (gnt[1] !== 1'b0) begin nfail++; $display("FAIL flush_wait flush_gnt got %b want 0", gnt[1]); end
        if (rv[1] !== 1'b0) begin nfail++; $display("FAIL flush_wait flush_rvalid got %b want 0", rv[1]); end
        step();
        flush = 1'b0;
        @(negedge clk);
        ncmp++;
        if (gnt[1] !== 1'b1) begin nfail++; $display("FAIL flush_wait idle_gnt got %b want 1", gnt[1]); end
        for (int n = 0; n < 5; n++) begin
            ncmp++;
            if (rv[1] !== 1'b0) begin nfail++; $display("FAIL flush_wait late_rvalid n=%0d got %b want 0", n, rv[1]); end
            step();
            @(negedge clk);
        end
    endtask

    task automatic test_flush_resp();
        idle();
        req = 1'b1;
        addr = 32'h1000;
        @(negedge clk);
        ncmp++;
        if (gnt[0] !== 1'b1) begin nfail++; $display("FAIL flush_resp accept_gnt got %b want 1", gnt[0]); end
        step();
        flush = 1'b1;
        addr = 32'h1004;
        @(negedge clk);
        ncmp += 2;
        if (rv[0] !== 1'b0) begin nfail++; $display("FAIL flush_resp masked_rvalid got %b want 0", rv[0]); end
        if (gnt[0] !== 1'b0) begin nfail++; $display("FAIL flush_resp flush_req_gnt got %b want 0", gnt[0]); end
        step();
        flush = 1'b0;
        req = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            ncmp++;
            if (rv[0] !== 1'b0) begin nfail++; $display("FAIL flush_resp late_rvalid n=%0d got %b want 0", n, rv[0]); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        idle();
        req = 1'b1;
        addr = 32'h1008;
        step();
        req = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        ncmp += 4;
        if (rv[2] !== 1'b0) begin nfail++; $display("FAIL reset_mid rvalid got %b want 0", rv[2]); end
        if (rd[2] !== RV_NOP) begin nfail++; $display("FAIL reset_mid rdata got %h want %h", rd[2], RV_NOP); end
        if (gnt[2] !== 1'b1) begin nfail++; $display("FAIL reset_mid gnt got %b want 1", gnt[2]); end
        if (er[2] !== 1'b0) begin nfail++; $display("FAIL reset_mid err got %b want 0", er[2]); end
        for (int n = 0; n < 5; n++) begin
            step();
            @(negedge clk);
            ncmp++;
            if (rv[2] !== 1'b0) begin nfail++; $display("FAIL reset_mid late_rvalid n=%0d got %b want 0", n, rv[2]); end
        end
    endtask

    task automatic test_collision();
        data_t old_w;
        idle();
        old_w = model(32'h100C).data;
        req = 1'b1;
        addr = 32'h100C;
        ld_en = 1'b1;
        ld_addr = 32'h100C;
        ld_data = 32'hDEAD_BEEF;
        @(negedge clk);
        ncmp++;
        if (gnt[0] !== 1'b1) begin nfail++; $display("FAIL collision gnt got %b want 1", gnt[0]); end
        step();
        mem_m[3] = 32'hDEAD_BEEF;
        req = 1'b0;
        ld_en = 1'b0;
        @(negedge clk);
        ncmp += 2;
        if (rv[0] !== 1'b1) begin nfail++; $display("FAIL collision rvalid got %b want 1", rv[0]); end
        if (rd[0] !== old_w) begin nfail++; $display("FAIL collision old_data got %h want %h", rd[0], old_w); end
        step();
        req = 1'b1;
        step();
        req = 1'b0;
        @(negedge clk);
        ncmp += 2;
        if (rv[0] !== 1'b1) begin nfail++; $display("FAIL collision new_rvalid got %b want 1", rv[0]); end
        if (rd[0] !== model(32'h100C).data) begin nfail++; $display("FAIL collision new_data got %h want %h", rd[0], model(32'h100C).data); end
    endtask

    initial begin
        test_reset();
        do_loads();
        alist = '{32'h1000, 32'h1004, 32'h1008, 32'h1FFC, 32'h100C};
        test_fetch(0, "fetch_w0");
        alist = '{32'h1002, 32'h0FFC, 32'h2000, 32'hFFFF_FFFC, 32'h1000};
        test_fetch(0, "errors_w0");
        alist = '{32'h1000, 32'h1004};
        test_fetch(2, "back_to_back_w3");
        alist = '{32'h1008, 32'h1003, 32'h1FFC};
        test_fetch(1, "fetch_w2");
        test_flush_wait();
        test_flush_resp();
        test_reset_mid();
        test_collision();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
